i2s_tx_sequencer: RTL and testbench

- Frame sequencer for the 16-bit bclk-domain audio shift-out serializer.
- Accepts stereo sample pairs from an upstream source over a valid/ready handshake, then presents left and right words to the serializer.
- Generates the serializer's one-cycle load strobe (act) once per word, drives the left/right word clock, and flags frame completion and underruns.
- Sits between the PCM sample source (mic/ADC path or buffer) and the serializer.

---
 rtl/i2s_pkg.sv | 14 +
 rtl/i2s_slot_counter.sv | 46 ++++
 rtl/i2s_tx_sequencer.sv | 114 +++++++++++
 tb/tb_i2s_tx_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit sequencer and its slot counter.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int   WIDTH_DEFAULT = 16;
  localparam logic CH_LEFT       = 1'b0;
  localparam logic CH_RIGHT      = 1'b1;

endpackage

// File: rtl/i2s_slot_counter.sv
// Bit/channel position within an I2S frame: WIDTH bits per word, left then right.
module i2s_slot_counter
  import i2s_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic bclk,
  input  logic reset,
  input  logic cnt_en_i,
  input  logic clr_i,
  output logic ch_o,
  output logic word_start_o,
  output logic frame_last_o
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] bit_cnt_q;
  logic          ch_q;

  // Bit position advances every enabled edge; channel flips on the word wrap.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
      ch_q      <= CH_LEFT;
    end else if (clr_i) begin
      bit_cnt_q <= '0;
      ch_q      <= CH_LEFT;
    end else if (cnt_en_i) begin
      if (bit_cnt_q == LAST) begin
        bit_cnt_q <= '0;
        ch_q      <= ~ch_q;
      end else begin
        bit_cnt_q <= bit_cnt_q + CW'(1);
      end
    end else begin
      bit_cnt_q <= bit_cnt_q;
    end
  end

  assign ch_o         = ch_q;
  assign word_start_o = (bit_cnt_q == '0);
  assign frame_last_o = (ch_q == CH_RIGHT) && (bit_cnt_q == LAST);

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S transmit frame sequencer: pair handshake, word load strobes, lrclk, done, underrun.
// Optional 16-bit saturating underrun event counter when I2S_TX_UNDERRUN_CNT_EN is defined.
module i2s_tx_sequencer
  import i2s_pkg::*;
#(
  parameter int WIDTH            = WIDTH_DEFAULT,
  parameter int ZERO_ON_UNDERRUN = 0
) (
  input  logic             bclk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] l_data_i,
  input  logic [WIDTH-1:0] r_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic             act_o,
  output logic [WIDTH-1:0] word_out_o,
  output logic             lrclk_o,
  output logic             done_o,
  output logic             underrun_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]      underrun_cnt_o
`endif
);

  state_e           state_q;
  logic [WIDTH-1:0] l_hold_q;
  logic [WIDTH-1:0] r_hold_q;
  logic             underrun_q;

  logic run_s;
  logic ch_s;
  logic word_start_s;
  logic frame_last_s;
  logic take_s;

  assign run_s = (state_q == RUN);

  i2s_slot_counter #(
    .WIDTH(WIDTH)
  ) u_slot (
    .bclk        (bclk),
    .reset       (reset),
    .cnt_en_i    (run_s),
    .clr_i       (!run_s),
    .ch_o        (ch_s),
    .word_start_o(word_start_s),
    .frame_last_o(frame_last_s)
  );

  // Pair is offered in PRIME and, if the run continues, on the last bit of each frame.
  assign take_s = (state_q == PRIME) || (run_s && frame_last_s && enable_i);

  // Frame FSM plus hold registers; holds only move on a handshake slot.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      l_hold_q   <= '0;
      r_hold_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i) state_q <= PRIME;
          else          underrun_q <= 1'b0;
        end
        PRIME: state_q <= RUN;
        RUN: begin
          if (frame_last_s && !enable_i) state_q <= IDLE;
          else                           state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
      if (take_s) begin
        if (s_valid_i) begin
          l_hold_q <= l_data_i;
          r_hold_q <= r_data_i;
        end else begin
          underrun_q <= 1'b1;
          if (ZERO_ON_UNDERRUN != 0) begin
            l_hold_q <= '0;
            r_hold_q <= '0;
          end
        end
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  // Saturating count of missed pairs; only reset clears it.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      underrun_cnt_q <= 16'h0000;
    end else if (take_s && !s_valid_i && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'h0001;
    end else begin
      underrun_cnt_q <= underrun_cnt_q;
    end
  end

  assign underrun_cnt_o = underrun_cnt_q;
`endif

  assign s_ready_o  = take_s;
  assign act_o      = run_s && word_start_s;
  assign lrclk_o    = run_s && ch_s;
  assign word_out_o = run_s ? (ch_s ? r_hold_q : l_hold_q) : '0;
  assign done_o     = run_s && frame_last_s;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed bench for i2s_tx_sequencer: two instances (repeat / zero on underrun) share stimulus.
module tb_i2s_tx_sequencer;

  logic        bclk;
  logic        reset;
  logic        enable;
  logic [15:0] l_data;
  logic [15:0] r_data;
  logic        s_valid;

  logic        s_ready0, act0, lrclk0, done0, underrun0;
  logic [15:0] word0;
  logic        s_ready1, act1, lrclk1, done1, underrun1;
  logic [15:0] word1;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt0, ucnt1;
`endif

  int tests = 0;
  int fails = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];

  i2s_tx_sequencer #(.WIDTH(16), .ZERO_ON_UNDERRUN(0)) dut0 (
    .bclk(bclk), .reset(reset), .enable_i(enable), .l_data_i(l_data), .r_data_i(r_data),
    .s_valid_i(s_valid), .s_ready_o(s_ready0), .act_o(act0), .word_out_o(word0),
    .lrclk_o(lrclk0), .done_o(done0), .underrun_o(underrun0)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt_o(ucnt0)
`endif
  );

  i2s_tx_sequencer #(.WIDTH(16), .ZERO_ON_UNDERRUN(1)) dut1 (
    .bclk(bclk), .reset(reset), .enable_i(enable), .l_data_i(l_data), .r_data_i(r_data),
    .s_valid_i(s_valid), .s_ready_o(s_ready1), .act_o(act1), .word_out_o(word1),
    .lrclk_o(lrclk1), .done_o(done1), .underrun_o(underrun1)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt_o(ucnt1)
`endif
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge bclk);
    #1;
  endtask

  task automatic push(input logic [15:0] l0, input logic [15:0] r0,
                      input logic [15:0] l1, input logic [15:0] r1);
    q0.push_back({1'b0, l0});
    q0.push_back({1'b1, r0});
    q1.push_back({1'b0, l1});
    q1.push_back({1'b1, r1});
  endtask

  // Scoreboard: every load strobe must present the next expected {lrclk, word}.
  always @(negedge bclk) begin
    if (!reset) begin
      if (act0) begin
        if (q0.size() == 0) chk("sb_repeat_unexpected_act", 32'd1, 32'd0);
        else chk("sb_repeat_word", {15'd0, lrclk0, word0}, {15'd0, q0.pop_front()});
      end
      if (act1) begin
        if (q1.size() == 0) chk("sb_zero_unexpected_act", 32'd1, 32'd0);
        else chk("sb_zero_word", {15'd0, lrclk1, word1}, {15'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; s_valid = 1'b0; l_data = 16'h0000; r_data = 16'h0000;
    tick(2);
    chk("rst_act", {31'd0, act0}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready0}, 32'd0);
    chk("rst_word", {16'd0, word0}, 32'd0);
    chk("rst_lrclk_done_ur", {29'd0, lrclk0, done0, underrun0}, 32'd0);

    // Frame 1: pair 1234/ABCD accepted in PRIME.
    reset = 1'b0; enable = 1'b1; s_valid = 1'b1; l_data = 16'h1234; r_data = 16'hABCD;
    tick(1);
    chk("prime_s_ready", {31'd0, s_ready0}, 32'd1);
    chk("prime_act", {31'd0, act0}, 32'd0);
    push(16'h1234, 16'hABCD, 16'h1234, 16'hABCD);
    tick(1);
    chk("left_act", {31'd0, act0}, 32'd1);
    chk("left_word", {16'd0, word0}, 32'h1234);
    chk("left_s_ready", {31'd0, s_ready0}, 32'd0);
    l_data = 16'h0001; r_data = 16'h0002;
    tick(16);
    chk("right_act", {31'd0, act0}, 32'd1);
    chk("right_word", {16'd0, word0}, 32'hABCD);
    chk("right_lrclk", {31'd0, lrclk0}, 32'd1);
    tick(15);
    chk("frame1_done", {31'd0, done0}, 32'd1);
    chk("frame1_end_s_ready", {31'd0, s_ready0}, 32'd1);
    push(16'h0001, 16'h0002, 16'h0001, 16'h0002);

    // Frame 2 follows with no gap; underrun pending at its end.
    tick(1);
    chk("frame2_act", {31'd0, act0}, 32'd1);
    chk("frame2_word", {16'd0, word0}, 32'h0001);
    chk("frame2_done_low", {31'd0, done0}, 32'd0);
    chk("frame2_underrun", {31'd0, underrun0}, 32'd0);
    s_valid = 1'b0;
    tick(31);
    chk("frame2_done", {31'd0, done0}, 32'd1);
    chk("frame2_pre_underrun", {31'd0, underrun0}, 32'd0);
    push(16'h0001, 16'h0002, 16'h0000, 16'h0000);
    tick(1);
    chk("ur_sticky_repeat", {31'd0, underrun0}, 32'd1);
    chk("ur_sticky_zero", {31'd0, underrun1}, 32'd1);
    chk("ur_zero_word", {16'd0, word1}, 32'h0000);

    // Drop enable mid-frame; the frame still completes.
    tick(10);
    enable = 1'b0;
    tick(21);
    chk("drop_done", {31'd0, done0}, 32'd1);
    chk("drop_s_ready", {31'd0, s_ready0}, 32'd0);
    tick(1);
    chk("idle_act", {31'd0, act0}, 32'd0);
    chk("idle_ur_kept", {31'd0, underrun0}, 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("cnt_one", {16'd0, ucnt0}, 32'd1);
`endif
    tick(1);
    chk("idle_ur_cleared", {31'd0, underrun0}, 32'd0);
    tick(4);
    chk("idle_still", {30'd0, act0, s_ready0}, 32'd0);

    // Reset in the middle of the right word.
    enable = 1'b1; s_valid = 1'b1; l_data = 16'h5555; r_data = 16'hAAAA;
    tick(1);
    chk("m_prime_s_ready", {31'd0, s_ready0}, 32'd1);
    push(16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA);
    tick(19);
    reset = 1'b1;
    #1;
    chk("abort_outputs", {27'd0, act0, s_ready0, lrclk0, done0, underrun0}, 32'd0);
    chk("abort_word", {16'd0, word0}, 32'd0);
    tick(1);
    reset = 1'b0; s_valid = 1'b0;

    // Restart with three consecutive underruns (holds are zero after reset).
    tick(1);
    chk("restart_s_ready", {31'd0, s_ready0}, 32'd1);
    chk("restart_act", {31'd0, act0}, 32'd0);
    push(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tick(1);
    chk("restart_act_latency", {31'd0, act0}, 32'd1);
    chk("restart_underrun", {31'd0, underrun0}, 32'd1);
    tick(31);
    chk("ur2_done", {31'd0, done0}, 32'd1);
    push(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tick(32);
    chk("ur3_done", {31'd0, done0}, 32'd1);
    push(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tick(1);
    enable = 1'b0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("cnt_three", {16'd0, ucnt0}, 32'd3);
    chk("cnt_three_zero", {16'd0, ucnt1}, 32'd3);
`endif
    tick(34);
    chk("final_ur_cleared", {31'd0, underrun0}, 32'd0);
    chk("final_act", {31'd0, act0}, 32'd0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("cnt_kept", {16'd0, ucnt0}, 32'd3);
`endif
    chk("sb_repeat_drained", q0.size(), 32'd0);
    chk("sb_zero_drained", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
